// File: rtl/pc_flag_unit_pkg.sv
// Shared processor constants for the PC/flag unit: opcodes, condition codes,
// flag bit positions, run-state encoding and the branch-offset helper.
package pc_flag_unit_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_t;

  // imm9 is a signed word offset; convert to a byte offset
  function automatic logic [15:0] branch_offset(input logic [8:0] imm9);
    return {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/pc_flag_unit_if.sv
// Instruction-side bus between decode/ALU (master) and the PC/flag unit (slave).
interface pc_flag_unit_if;
  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] reg_target;
  logic [2:0]  alu_flags;
  logic [2:0]  flag_en;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic [2:0]  flags_q;
  logic        branch_taken;
  logic        halted;

  modport master (
    output opcode, cond, imm9, reg_target, alu_flags, flag_en,
    input  pc_out, pc_plus2, flags_q, branch_taken, halted
  );

  modport slave (
    input  opcode, cond, imm9, reg_target, alu_flags, flag_en,
    output pc_out, pc_plus2, flags_q, branch_taken, halted
  );
endinterface

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder/subtractor built from four 4-bit lookahead groups.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);

  logic [15:0] bx;
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gc;

  assign bx = b ^ {16{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  always_comb begin
    logic grp_g;
    logic grp_p;
    logic cc;
    sum   = '0;
    gc    = '0;
    gc[0] = sub;
    for (int k = 0; k < 4; k++) begin
      cc = gc[k];
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ cc;
        cc = g[4*k+j] | (p[4*k+j] & cc);
      end
      // group carry comes from lookahead terms, not the ripple above
      grp_g = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      if (k < 3) gc[k+1] = grp_g | (grp_p & gc[k]);
    end
  end

endmodule

// File: rtl/pc_flag_unit_cond_eval.sv
// Branch condition evaluation against the registered N/Z/V flags.
module cond_eval
  import pc_flag_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n;
  logic z;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE: taken = ~z;
      CC_EQ: taken = z;
      CC_GT: taken = ~z & ~n;
      CC_LT: taken = n;
      CC_GE: taken = z | (~z & ~n);
      CC_LE: taken = n | z;
      CC_OV: taken = v;
      CC_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// Program counter, N/Z/V flag register and sticky halt for the branch path.
//   state   | meaning
//   ST_RUN  | executing: PC advances or redirects, flags take ALU writes
//   ST_HALT | HLT retired: PC and flags frozen until reset
module pc_flag_unit
  import pc_flag_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pc_flag_unit_if.slave  bus
);

  run_state_t  state_q;
  run_state_t  state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [2:0]  flags_r;
  logic [2:0]  flags_d;
  logic [15:0] pc_inc;
  logic [15:0] b_target;
  logic        cond_true;
  logic        take;

  cla_16bit u_inc (
    .a   (pc_q),
    .b   (16'h0002),
    .sub (1'b0),
    .sum (pc_inc)
  );

  cla_16bit u_btgt (
    .a   (pc_inc),
    .b   (branch_offset(bus.imm9)),
    .sub (1'b0),
    .sum (b_target)
  );

  cond_eval u_cond (
    .cond  (bus.cond),
    .flags (flags_r),
    .taken (cond_true)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= 16'h0000;
      flags_r <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_r <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_r;
    take    = 1'b0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.flag_en[i]) flags_d[i] = bus.alu_flags[i];
      end
      case (bus.opcode)
        OP_B: begin
          take = cond_true;
          pc_d = cond_true ? b_target : pc_inc;
        end
        OP_BR: begin
          take = cond_true;
          pc_d = cond_true ? bus.reg_target : pc_inc;
        end
        OP_HLT: begin
          pc_d    = pc_q;
          state_d = ST_HALT;
        end
        OP_PCS:  pc_d = pc_inc;
        default: pc_d = pc_inc;
      endcase
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus2     = pc_inc;
  assign bus.flags_q      = flags_r;
  assign bus.branch_taken = take;
  assign bus.halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed-vector bench for pc_flag_unit with hand-computed expectations.
module tb_pc_flag_unit;
  import pc_flag_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pc_flag_unit_if bus ();

  pc_flag_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] cc, input logic [8:0] imm,
                       input logic [15:0] tgt, input logic [2:0] fen, input logic [2:0] af);
    bus.opcode     = op;
    bus.cond       = cc;
    bus.imm9       = imm;
    bus.reg_target = tgt;
    bus.flag_en    = fen;
    bus.alu_flags  = af;
  endtask

  logic [7:0] cond_exp;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(4'h0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
    tick();
    check_val("rst_pc", bus.pc_out, 16'h0000);
    check_val("rst_flags", {13'h0, bus.flags_q}, 16'h0000);
    check_val("rst_halted", {15'h0, bus.halted}, 16'h0000);
    check_val("rst_pc_plus2", bus.pc_plus2, 16'h0002);
    check_val("rst_taken", {15'h0, bus.branch_taken}, 16'h0000);

    rst_n = 1'b1;
    tick(); check_val("seq_pc1", bus.pc_out, 16'h0002);
    tick(); check_val("seq_pc2", bus.pc_out, 16'h0004);
    tick(); check_val("seq_pc3", bus.pc_out, 16'h0006);
    for (int i = 0; i < 5; i++) tick();
    check_val("seq_pc_10", bus.pc_out, 16'h0010);

    // backward branch: 0x0012 + (-4)
    drive(OP_B, CC_AL, 9'h1FE, 16'h0000, 3'b000, 3'b000);
    #1 check_val("b_back_taken", {15'h0, bus.branch_taken}, 16'h0001);
    tick(); check_val("b_back_pc", bus.pc_out, 16'h000E);

    drive(OP_BR, CC_AL, 9'h000, 16'h0020, 3'b000, 3'b000);
    tick(); check_val("br_to_20", bus.pc_out, 16'h0020);

    // flags written this cycle are not visible to this cycle's branch
    drive(OP_B, CC_EQ, 9'h004, 16'h0000, 3'b111, 3'b010);
    #1 check_val("flag_same_cycle", {15'h0, bus.branch_taken}, 16'h0000);
    tick();
    check_val("flag_nt_pc", bus.pc_out, 16'h0022);
    check_val("flag_written", {13'h0, bus.flags_q}, 16'h0002);

    drive(OP_BR, CC_AL, 9'h000, 16'h0020, 3'b000, 3'b000);
    tick();
    drive(OP_B, CC_EQ, 9'h004, 16'h0000, 3'b000, 3'b000);
    #1 check_val("flag_next_taken", {15'h0, bus.branch_taken}, 16'h0001);
    tick(); check_val("flag_next_pc", bus.pc_out, 16'h002A);

    // largest positive offset: 0x002C + 0x01FE
    drive(OP_B, CC_AL, 9'h0FF, 16'h0000, 3'b000, 3'b000);
    tick(); check_val("b_fwd_max", bus.pc_out, 16'h022A);

    drive(4'h0, 3'b000, 9'h000, 16'h0000, 3'b111, 3'b111);
    tick(); check_val("flags_all_set", {13'h0, bus.flags_q}, 16'h0007);
    drive(4'h0, 3'b000, 9'h000, 16'h0000, 3'b010, 3'b000);
    tick(); check_val("flags_partial", {13'h0, bus.flags_q}, 16'h0005);

    // flags N=1 Z=0 V=1: expected taken per cond code, bit index = cond
    cond_exp = 8'b1110_1001;
    for (int c = 0; c < 8; c++) begin
      drive(OP_B, c[2:0], 9'h000, 16'h0000, 3'b000, 3'b000);
      #1 check_val($sformatf("cond_%0d", c), {15'h0, bus.branch_taken}, {15'h0, cond_exp[c]});
    end

    drive(OP_BR, CC_AL, 9'h000, 16'hFFFE, 3'b000, 3'b000);
    tick();
    check_val("wrap_pc", bus.pc_out, 16'hFFFE);
    check_val("wrap_plus2", bus.pc_plus2, 16'h0000);
    drive(OP_PCS, CC_AL, 9'h000, 16'h0000, 3'b000, 3'b000);
    #1 check_val("pcs_no_take", {15'h0, bus.branch_taken}, 16'h0000);
    tick(); check_val("wrap_next", bus.pc_out, 16'h0000);

    drive(OP_BR, CC_OV, 9'h000, 16'h1234, 3'b000, 3'b000);
    #1 check_val("br_v_taken", {15'h0, bus.branch_taken}, 16'h0001);
    tick(); check_val("br_v_pc", bus.pc_out, 16'h1234);
    drive(OP_BR, CC_AL, 9'h000, 16'h1235, 3'b000, 3'b000);
    tick(); check_val("br_odd_pc", bus.pc_out, 16'h1235);
    drive(OP_BR, CC_AL, 9'h000, 16'h0040, 3'b000, 3'b000);
    tick(); check_val("br_to_40", bus.pc_out, 16'h0040);

    // HLT still lets this edge's flag write land
    drive(OP_HLT, CC_AL, 9'h000, 16'h0000, 3'b111, 3'b000);
    #1 check_val("hlt_no_take", {15'h0, bus.branch_taken}, 16'h0000);
    tick();
    check_val("hlt_halted", {15'h0, bus.halted}, 16'h0001);
    check_val("hlt_pc", bus.pc_out, 16'h0040);
    check_val("hlt_flags", {13'h0, bus.flags_q}, 16'h0000);

    drive(OP_B, CC_AL, 9'h1FE, 16'h0000, 3'b111, 3'b111);
    #1 check_val("halt_no_take", {15'h0, bus.branch_taken}, 16'h0000);
    tick();
    check_val("halt_pc_hold", bus.pc_out, 16'h0040);
    check_val("halt_flags_hold", {13'h0, bus.flags_q}, 16'h0000);
    tick();
    check_val("halt_sticky", {15'h0, bus.halted}, 16'h0001);
    check_val("halt_pc_hold2", bus.pc_out, 16'h0040);

    rst_n = 1'b0;
    tick();
    check_val("rst2_pc", bus.pc_out, 16'h0000);
    check_val("rst2_halted", {15'h0, bus.halted}, 16'h0000);
    check_val("rst2_flags", {13'h0, bus.flags_q}, 16'h0000);
    rst_n = 1'b1;
    drive(4'h0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
    #1;
    check_val("rst2_plus2", bus.pc_plus2, 16'h0002);
    check_val("rst2_taken", {15'h0, bus.branch_taken}, 16'h0000);
    tick(); check_val("rst2_run", bus.pc_out, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_flag_unit.md
PC_FLAG_UNIT -- requirements
Module: pc_flag_unit

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: opcode  input  4  current instruction opcode (1100 B, 1101 BR, 1110 PCS, 1111 HLT).
REQ-004 SHALL have: cond  input  3  branch condition field.
REQ-005 SHALL have: imm9  input  9  signed word offset for B.
REQ-006 SHALL have: reg_target  input  16  register-file read value, the BR target.
REQ-007 SHALL have: alu_flags  input  3  ALU flags; bit2 N, bit1 Z, bit0 V.
REQ-008 SHALL have: flag_en  input  3  per-bit flag write enables from ALU, same bit order.
REQ-009 SHALL have: pc_out  output  16  registered PC, instruction-fetch address.
REQ-010 SHALL have: pc_plus2  output  16  pc_out+2, combinational; PCS write-back data.
REQ-011 SHALL have: flags_q  output  3  registered N/Z/V flags.
REQ-012 SHALL have: branch_taken  output  1  combinational; current B/BR redirects PC.
REQ-013 SHALL have: halted  output  1  registered, sticky halt indicator.

Function
REQ-014 SHALL compute pc_plus2 = pc_out + 2 modulo 2^16 (0xFFFE -> 0x0000).
REQ-015 SHALL compute B target = pc_plus2 + (sign-extended imm9 << 1), modulo 2^16.
REQ-016 SHALL evaluate cond against flags_q (flags before this instruction's update): 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-017 SHALL assert branch_taken only when opcode is B or BR, condition true, and halted=0.
REQ-018 SHALL set next PC: B taken -> B target; BR taken -> reg_target; HLT -> pc_out (hold); otherwise pc_plus2.
REQ-019 SHALL, on HLT with halted=0, set halted=1 next edge; halted SHALL stay 1 until reset.
REQ-020 SHALL, while halted=1, hold pc_out and flags_q regardless of inputs.
REQ-021 SHALL update each flags_q[i] to alu_flags[i] at the edge iff flag_en[i]=1 and halted=0; disabled bits hold.
REQ-022 SHALL treat flags updated by an instruction as visible to the next instruction's branch (one-cycle latency), not the same one.
REQ-023 SHALL use reg_target unmodified for BR (no alignment forcing).
REQ-024 SHALL give HLT priority: it never redirects, even if flag_en nonzero; flag writes still follow REQ-021.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, set pc_out=0x0000, flags_q=000, halted=0.
REQ-026 SHALL let reset override a simultaneous HLT, branch or flag write, including mid-halt.
REQ-027 SHALL drive pc_plus2=0x0002 and branch_taken=0 in the cycle after reset, with non-branch opcode.

Structure
REQ-028 SHALL take opcode constants (B, BR, PCS, HLT), condition codes and flag bit indices (N=2, Z=1, V=0) from the shared processor package.
REQ-029 SHALL place condition evaluation in one combinational sub-module, cond_eval (inputs cond, flags; output taken).
REQ-030 SHALL build both 16-bit adders from the existing cla_16bit adder with sub=0.

Verification
REQ-031 SHALL cover reset: rst_n=0 one edge -> pc_out=0x0000, flags_q=000, halted=0; 3 non-branch cycles -> pc_out 0x0002, 0x0004, 0x0006.
REQ-032 SHALL cover B backward: pc_out=0x0010, opcode B, cond=111, imm9=0x1FE (-2) -> branch_taken=1, next pc_out=0x000E.
REQ-033 SHALL cover flag timing: cycle n flag_en=111, alu_flags=010; cycle n+1 B cond=001 imm9=0x004 at pc 0x0020 -> taken, next pc_out=0x002A; same B in cycle n -> not taken.
REQ-034 SHALL cover partial enable: flags_q=111, flag_en=010, alu_flags=000 -> flags_q=101.
REQ-035 SHALL cover BR and wrap: pc_out=0xFFFE non-branch -> 0x0000; BR cond=110, V=1, reg_target=0x1234 -> next pc_out=0x1234.
REQ-036 SHALL cover halt: HLT at pc 0x0040 -> halted=1, pc_out stays 0x0040 with B cond=111 and flag_en=111 applied; rst_n=0 -> pc_out=0x0000, halted=0.
